alu_cmd_sequencer: RTL
======================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter LAT, default 1, ALU settle cycles from command issue to result capture; LAT=0 SHALL behave as LAT=1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  sequencer accepts request.
REQ-007 req_op  input  3  command: ADD=0 SUB=1 XOR=2 SLT=3 AND=4 NAND=5 NOR=6 OR=7.
REQ-008 req_a, req_b  input  WIDTH  operands.
REQ-009 alu_command  output  3  encoded command driven to ALU decoder.
REQ-010 alu_a, alu_b  output  WIDTH  operands driven to ALU.
REQ-011 alu_result  input  WIDTH  ALU result.
REQ-012 alu_carryout, alu_zero, alu_overflow  input  1 each  ALU flags.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_result  output  WIDTH  captured result.
REQ-016 rsp_flags  output  3  captured {overflow, carryout, zero}.
REQ-017 busy  output  1  high whenever state is not IDLE.
REQ-018 op_count  output  16  completed-response counter.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, RESP; one request in flight at a time.
REQ-020 req_ready SHALL equal (state==IDLE); no other condition.
REQ-021 IDLE: on edge with req_valid&&req_ready, register req_op/req_a/req_b into alu_command/alu_a/alu_b, load wait counter with max(LAT,1), go ISSUE.
REQ-022 IDLE with req_valid low: hold state; alu_command/alu_a/alu_b retain last issued values.
REQ-023 ISSUE: decrement counter each edge; on edge where counter==1, capture alu_result into rsp_result and flags into rsp_flags, set rsp_valid, go RESP.
REQ-024 Latency: accept at edge E0 -> rsp_valid high immediately after edge E0+max(LAT,1).
REQ-025 alu_command/alu_a/alu_b SHALL remain stable from accept edge through capture edge.
REQ-026 RESP: rsp_valid, rsp_result, rsp_flags held stable until rsp_valid&&rsp_ready edge; then rsp_valid=0, op_count+1, go IDLE.
REQ-027 rsp_ready asserted outside RESP SHALL have no effect; req_valid outside IDLE SHALL be ignored and the request not captured.
REQ-028 op_count SHALL wrap 16'hFFFF -> 16'h0000 without affecting other state.
REQ-029 Invalid state encodings SHALL return to IDLE on next edge with rsp_valid=0.
REQ-030 Sequencer SHALL NOT modify or interpret ALU results; SLT/flag semantics come from ALU.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_command=0 (ADD), alu_a=0, alu_b=0, op_count=0, counter=0.
REQ-032 Reset during ISSUE or RESP SHALL discard the in-flight request with no response and no count increment.
REQ-033 First request SHALL be acceptable on first rising edge after rst_n deasserts.

Verification
REQ-034 WIDTH=32, LAT=2, reference ALU model: ADD a=5 b=3 accepted at E0 -> alu_command=0 from E0; rsp_valid after E2; rsp_result=8, rsp_flags=000; op_count=1 after handshake.
REQ-035 SUB a=7 b=7 -> alu_command=1, rsp_result=0, rsp_flags=001; SLT a=2 b=9 -> alu_command=3, rsp_result=1.
REQ-036 Backpressure: rsp_ready low 5 cycles after rsp_valid -> rsp_valid/result/flags stable, req_ready=0, req_valid with new op ignored; rsp_ready high -> IDLE next edge, then new op accepted.
REQ-037 Reset mid-ISSUE (LAT=4, rst_n low at E2) -> all outputs at REQ-031 values, no rsp_valid, op_count=0; next request completes normally.
REQ-038 Preload path via 65535 completed ops (or forced counter) -> op_count 16'hFFFF -> 16'h0000 on next completion.
REQ-039 LAT=0 build: ADD 1+1 -> rsp_valid after E1, rsp_result=2 (identical to LAT=1).

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command sequencer: latches one request into the ALU operand
// registers, waits a fixed settle time, captures the result and holds it until consumed.
module alu_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [2:0]       alu_command,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_flags,
  output logic             busy,
  output logic [15:0]      op_count
);

  // A zero settle time still needs one cycle for the ALU to see the operands.
  localparam int LAT_EFF = (LAT < 1) ? 1 : LAT;
  localparam int CW      = $clog2(LAT_EFF + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT_EFF);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [2:0]       cmd_r, cmd_nxt_s;
  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic [WIDTH-1:0] b_r, b_nxt_s;
  logic             rsp_valid_r, rsp_valid_nxt_s;
  logic [WIDTH-1:0] rsp_result_r, rsp_result_nxt_s;
  logic [2:0]       rsp_flags_r, rsp_flags_nxt_s;
  logic [15:0]      op_count_r, op_count_nxt_s;

  // Next-state and datapath update for the request/issue/response cycle.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    cmd_nxt_s        = cmd_r;
    a_nxt_s          = a_r;
    b_nxt_s          = b_r;
    rsp_valid_nxt_s  = rsp_valid_r;
    rsp_result_nxt_s = rsp_result_r;
    rsp_flags_nxt_s  = rsp_flags_r;
    op_count_nxt_s   = op_count_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          cmd_nxt_s   = req_op;
          a_nxt_s     = req_a;
          b_nxt_s     = req_b;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        // Capture on the last settle cycle; a zero count cannot strand the FSM.
        if (cnt_r <= CNT_ONE) begin
          cnt_nxt_s        = CNT_ZERO;
          rsp_result_nxt_s = alu_result;
          rsp_flags_nxt_s  = {alu_overflow, alu_carryout, alu_zero};
          rsp_valid_nxt_s  = 1'b1;
          state_nxt_s      = RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt_s = 1'b0;
          op_count_nxt_s  = op_count_r + 16'd1;
          state_nxt_s     = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        cnt_nxt_s       = CNT_ZERO;
        rsp_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      cmd_r        <= 3'd0;
      a_r          <= '0;
      b_r          <= '0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= '0;
      rsp_flags_r  <= 3'd0;
      op_count_r   <= 16'd0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      cmd_r        <= cmd_nxt_s;
      a_r          <= a_nxt_s;
      b_r          <= b_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_result_r <= rsp_result_nxt_s;
      rsp_flags_r  <= rsp_flags_nxt_s;
      op_count_r   <= op_count_nxt_s;
    end
  end

  assign req_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign alu_command = cmd_r;
  assign alu_a       = a_r;
  assign alu_b       = b_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_result  = rsp_result_r;
  assign rsp_flags   = rsp_flags_r;
  assign op_count    = op_count_r;

endmodule
